logic_dispatch: RTL and testbench

//   Issue-side driver for the logical unit. Accepts one 19-bit instruction word per handshake.

---
 rtl/logic_dispatch.sv | 132 +++++++++++++
 tb/tb_logic_dispatch.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_dispatch.sv
// logic_dispatch: accepts one logical-op instruction at a time, reads its sources from a
// synchronous register file, runs it through the logical unit and writes the result back.
`default_nettype none

module logic_dispatch #(
    parameter int              WORD_SIZE = 19,
    parameter int              REG_AW    = 4,
    parameter int              OPC_W     = 5,
    parameter logic [OPC_W-1:0] OPC_AND  = 5'h08,
    parameter logic [OPC_W-1:0] OPC_OR   = 5'h09,
    parameter logic [OPC_W-1:0] OPC_XOR  = 5'h0A,
    parameter logic [OPC_W-1:0] OPC_NOT  = 5'h0B
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    input  logic [WORD_SIZE-1:0] instr,
    output logic                 instr_ready,
    output logic [REG_AW-1:0]    rf_raddr1,
    output logic [REG_AW-1:0]    rf_raddr2,
    input  logic [WORD_SIZE-1:0] rf_rdata1,
    input  logic [WORD_SIZE-1:0] rf_rdata2,
    output logic [OPC_W-1:0]     lu_opcode,
    output logic [WORD_SIZE-1:0] lu_op1,
    output logic [WORD_SIZE-1:0] lu_op2,
    input  logic [WORD_SIZE-1:0] lu_result,
    output logic                 wb_en,
    output logic [REG_AW-1:0]    wb_addr,
    output logic [WORD_SIZE-1:0] wb_data,
    output logic                 done,
    output logic                 illegal,
    output logic                 zero
);

    localparam int RD_MSB  = WORD_SIZE - OPC_W - 1;
    localparam int RS1_MSB = RD_MSB - REG_AW;
    localparam int RS2_MSB = RS1_MSB - REG_AW;
    localparam int RSV_W   = RS2_MSB - REG_AW + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        EXEC = 3'd2,
        WB   = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t             state;
    logic [OPC_W-1:0]   ir_opc;
    logic [REG_AW-1:0]  ir_rd;

    logic [OPC_W-1:0]   dec_opc;
    logic [RSV_W-1:0]   dec_rsv;
    logic               dec_legal;

    assign dec_opc   = instr[WORD_SIZE-1 -: OPC_W];
    assign dec_rsv   = instr[RSV_W-1:0];
    assign dec_legal = ((dec_opc == OPC_AND) || (dec_opc == OPC_OR) ||
                        (dec_opc == OPC_XOR) || (dec_opc == OPC_NOT)) &&
                       (dec_rsv == '0);

    // Gated by rst_n so the source sees not-ready while reset is held.
    assign instr_ready = rst_n && (state == IDLE);

    // Read data only exists during EXEC, so the operand path cannot be registered.
    assign lu_opcode = (state == EXEC) ? ir_opc    : '0;
    assign lu_op1    = (state == EXEC) ? rf_rdata1 : '0;
    assign lu_op2    = (state == EXEC) ? rf_rdata2 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ir_opc    <= '0;
            ir_rd     <= '0;
            rf_raddr1 <= '0;
            rf_raddr2 <= '0;
            wb_en     <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            done      <= 1'b0;
            illegal   <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ir_opc    <= dec_opc;
                        ir_rd     <= instr[RD_MSB -: REG_AW];
                        rf_raddr1 <= instr[RS1_MSB -: REG_AW];
                        rf_raddr2 <= instr[RS2_MSB -: REG_AW];
                        if (dec_legal) begin
                            state <= READ;
                        end else begin
                            state   <= ERR;
                            done    <= 1'b1;
                            illegal <= 1'b1;
                        end
                    end
                end
                READ: begin
                    state <= EXEC;
                end
                EXEC: begin
                    wb_en   <= 1'b1;
                    done    <= 1'b1;
                    wb_addr <= ir_rd;
                    wb_data <= lu_result;
                    state   <= WB;
                end
                WB: begin
                    zero    <= (wb_data == '0);
                    wb_en   <= 1'b0;
                    done    <= 1'b0;
                    wb_addr <= '0;
                    wb_data <= '0;
                    state   <= IDLE;
                end
                ERR: begin
                    done    <= 1'b0;
                    illegal <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_logic_dispatch.sv
// Bench for logic_dispatch with a behavioural register file and logical unit.
`default_nettype none

module tb_logic_dispatch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [18:0] instr = '0;
    logic        instr_ready;
    logic [3:0]  rf_raddr1, rf_raddr2;
    logic [18:0] rf_rdata1, rf_rdata2;
    logic [4:0]  lu_opcode;
    logic [18:0] lu_op1, lu_op2, lu_result;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [18:0] wb_data;
    logic        done, illegal, zero;

    int total = 0;
    int bad   = 0;

    logic [18:0] regs [16];
    logic        poke_en = 1'b0;
    logic [3:0]  poke_addr = '0;
    logic [18:0] poke_data = '0;

    always #5 clk = ~clk;

    logic_dispatch dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .lu_opcode(lu_opcode),
        .lu_op1(lu_op1), .lu_op2(lu_op2), .lu_result(lu_result), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .done(done), .illegal(illegal), .zero(zero)
    );

    always @(posedge clk) begin
        rf_rdata1 <= regs[rf_raddr1];
        rf_rdata2 <= regs[rf_raddr2];
        if (poke_en) regs[poke_addr] <= poke_data;
        else if (wb_en) regs[wb_addr] <= wb_data;
    end

    always_comb begin
        lu_result = '0;
        case (lu_opcode)
            5'h08: lu_result = lu_op1 & lu_op2;
            5'h09: lu_result = lu_op1 | lu_op2;
            5'h0A: lu_result = lu_op1 ^ lu_op2;
            5'h0B: lu_result = ~lu_op1;
            default: lu_result = '0;
        endcase
    end

    function automatic logic [18:0] mk(input logic [4:0] opc, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2,
                                       input logic [1:0] rsv);
        return {opc, rd, rs1, rs2, rsv};
    endfunction

    task automatic poke(input logic [3:0] a, input logic [18:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    // Returns just after the accept edge (#1), i.e. in the first cycle after acceptance.
    task automatic send(input logic [18:0] w);
        int n;
        n = 0;
        @(negedge clk);
        instr = w; instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin
            @(negedge clk); n++;
        end
        total++;
        if (!instr_ready) begin
            bad++; $display("FAIL accept_timeout ready=%0b required=1", instr_ready);
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    task automatic run_legal(input logic [18:0] w, input logic [3:0] rd,
                             input logic [18:0] data, input logic exp_zero);
        send(w);
        total++;
        if (instr_ready !== 1'b0 || wb_en !== 1'b0 || rf_raddr1 !== w[9:6] || rf_raddr2 !== w[5:2]) begin
            bad++; $display("FAIL read_cycle ready=%0b wb_en=%0b raddr=%h/%h required 0/0 %h/%h",
                            instr_ready, wb_en, rf_raddr1, rf_raddr2, w[9:6], w[5:2]);
        end
        @(posedge clk); #1;
        total++;
        if (lu_opcode !== w[18:14] || wb_en !== 1'b0) begin
            bad++; $display("FAIL exec_cycle opcode=%h wb_en=%0b required %h/0", lu_opcode, wb_en, w[18:14]);
        end
        @(posedge clk); #1;
        total++;
        if (wb_en !== 1'b1 || done !== 1'b1 || illegal !== 1'b0 || wb_addr !== rd || wb_data !== data) begin
            bad++; $display("FAIL writeback en=%0b done=%0b ill=%0b addr=%h data=%h required 1/1/0 %h %h",
                            wb_en, done, illegal, wb_addr, wb_data, rd, data);
        end
        @(posedge clk); #1;
        total++;
        if (wb_en !== 1'b0 || done !== 1'b0 || wb_addr !== 4'h0 || wb_data !== 19'h0 ||
            instr_ready !== 1'b1 || zero !== exp_zero) begin
            bad++; $display("FAIL retire en=%0b done=%0b addr=%h data=%h ready=%0b zero=%0b required 0/0/0/0/1/%0b",
                            wb_en, done, wb_addr, wb_data, instr_ready, zero, exp_zero);
        end
    endtask

    task automatic test_reset;
        #2;
        total++;
        if (instr_ready !== 1'b0 || wb_en !== 1'b0 || done !== 1'b0 || illegal !== 1'b0 ||
            zero !== 1'b0 || lu_opcode !== 5'h0 || rf_raddr1 !== 4'h0 || wb_data !== 19'h0) begin
            bad++; $display("FAIL reset_values ready=%0b wb_en=%0b done=%0b ill=%0b zero=%0b opc=%h required all 0",
                            instr_ready, wb_en, done, illegal, zero, lu_opcode);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (instr_ready !== 1'b1) begin
            bad++; $display("FAIL ready_after_reset ready=%0b required=1", instr_ready);
        end
    endtask

    task automatic test_and;
        poke(4'd1, 19'h7FFFF);
        poke(4'd2, 19'h0F0F0);
        run_legal(mk(5'h08, 4'd3, 4'd1, 4'd2, 2'b00), 4'd3, 19'h0F0F0, 1'b0);
        total++;
        if (regs[3] !== 19'h0F0F0) begin
            bad++; $display("FAIL and_regfile r3=%h required=0F0F0", regs[3]);
        end
    endtask

    task automatic test_zero_flag;
        poke(4'd4, 19'h12345);
        run_legal(mk(5'h0A, 4'd5, 4'd4, 4'd4, 2'b00), 4'd5, 19'h00000, 1'b1);
        poke(4'd6, 19'h00001);
        run_legal(mk(5'h09, 4'd7, 4'd6, 4'd5, 2'b00), 4'd7, 19'h00001, 1'b0);
    endtask

    task automatic test_not;
        poke(4'd1, 19'h00000);
        poke(4'd15, 19'h5A5A5);
        send(mk(5'h0B, 4'd2, 4'd1, 4'hF, 2'b00));
        @(posedge clk); #1;
        total++;
        if (lu_op2 !== 19'h5A5A5 || lu_op1 !== 19'h00000 || lu_opcode !== 5'h0B) begin
            bad++; $display("FAIL not_operands op1=%h op2=%h opc=%h required 00000 5A5A5 0B", lu_op1, lu_op2, lu_opcode);
        end
        @(posedge clk); #1;
        total++;
        if (wb_en !== 1'b1 || wb_addr !== 4'd2 || wb_data !== 19'h7FFFF) begin
            bad++; $display("FAIL not_writeback en=%0b addr=%h data=%h required 1 2 7FFFF", wb_en, wb_addr, wb_data);
        end
        @(posedge clk); #1;
        total++;
        if (zero !== 1'b0 || regs[2] !== 19'h7FFFF) begin
            bad++; $display("FAIL not_retire zero=%0b r2=%h required 0 7FFFF", zero, regs[2]);
        end
    endtask

    task automatic test_illegal;
        logic [18:0] vec [2];
        poke(4'd4, 19'h12345);
        run_legal(mk(5'h0A, 4'd5, 4'd4, 4'd4, 2'b00), 4'd5, 19'h00000, 1'b1);
        vec[0] = mk(5'h1F, 4'd9, 4'd1, 4'd2, 2'b00);
        vec[1] = mk(5'h08, 4'd9, 4'd1, 4'd2, 2'b01);
        poke(4'd9, 19'h2AAAA);
        for (int i = 0; i < 2; i++) begin
            send(vec[i]);
            total++;
            if (done !== 1'b1 || illegal !== 1'b1 || wb_en !== 1'b0 || instr_ready !== 1'b0) begin
                bad++; $display("FAIL illegal_%0d done=%0b ill=%0b wb_en=%0b ready=%0b required 1/1/0/0",
                                i, done, illegal, wb_en, instr_ready);
            end
            @(posedge clk); #1;
            total++;
            if (done !== 1'b0 || illegal !== 1'b0 || instr_ready !== 1'b1 || zero !== 1'b1 || regs[9] !== 19'h2AAAA) begin
                bad++; $display("FAIL illegal_after_%0d done=%0b ill=%0b ready=%0b zero=%0b r9=%h required 0/0/1/1 2AAAA",
                                i, done, illegal, instr_ready, zero, regs[9]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [18:0] prog [3];
        int idx;
        logic exp_r, took;
        poke(4'd6, 19'h00FF0);
        poke(4'd7, 19'h0F00F);
        prog[0] = mk(5'h09, 4'd8, 4'd6, 4'd7, 2'b00);
        prog[1] = mk(5'h08, 4'd9, 4'd8, 4'd6, 2'b00);
        prog[2] = mk(5'h0A, 4'd8, 4'd8, 4'd9, 2'b00);
        idx = 0;
        @(negedge clk);
        instr = prog[0]; instr_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            exp_r = (c % 4 == 0);
            took  = instr_ready;
            total++;
            if (instr_ready !== exp_r) begin
                bad++; $display("FAIL b2b_ready cycle=%0d ready=%0b required=%0b", c, instr_ready, exp_r);
            end
            @(posedge clk); #1;
            if (took) begin
                idx++;
                if (idx < 3) instr = prog[idx];
                else instr_valid = 1'b0;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        total++;
        if (regs[8] !== 19'h0F00F || regs[9] !== 19'h00FF0 || idx != 3) begin
            bad++; $display("FAIL b2b_results r8=%h r9=%h accepts=%0d required 0F00F 00FF0 3", regs[8], regs[9], idx);
        end
    endtask

    task automatic test_midop_reset;
        int pulses;
        poke(4'd4, 19'h12345);
        run_legal(mk(5'h0A, 4'd5, 4'd4, 4'd4, 2'b00), 4'd5, 19'h00000, 1'b1);
        poke(4'd1, 19'h7FFFF);
        poke(4'd2, 19'h0F0F0);
        poke(4'd10, 19'h11111);
        send(mk(5'h08, 4'd10, 4'd1, 4'd2, 2'b00));
        @(posedge clk); #1;
        total++;
        if (lu_opcode !== 5'h08 || lu_op1 !== 19'h7FFFF) begin
            bad++; $display("FAIL midop_exec opc=%h op1=%h required 08 7FFFF", lu_opcode, lu_op1);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (lu_opcode !== 5'h0 || lu_op1 !== 19'h0 || lu_op2 !== 19'h0 || wb_en !== 1'b0 || done !== 1'b0 ||
            zero !== 1'b0 || instr_ready !== 1'b0 || rf_raddr1 !== 4'h0) begin
            bad++; $display("FAIL midop_reset opc=%h op1=%h wb_en=%0b done=%0b zero=%0b ready=%0b required all 0",
                            lu_opcode, lu_op1, wb_en, done, zero, instr_ready);
        end
        pulses = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (wb_en || done) pulses++;
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (instr_ready !== 1'b1) begin
            bad++; $display("FAIL midop_ready ready=%0b required=1", instr_ready);
        end
        repeat (4) begin
            if (wb_en || done) pulses++;
            @(posedge clk); #1;
        end
        total++;
        if (pulses != 0 || regs[10] !== 19'h11111) begin
            bad++; $display("FAIL midop_dropped pulses=%0d r10=%h required 0 11111", pulses, regs[10]);
        end
    endtask

    initial begin
        test_reset();
        test_and();
        test_zero_flag();
        test_not();
        test_illegal();
        test_back_to_back();
        test_midop_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
